// File: rtl/div_nr_pkg.sv
// Shared definitions for the div_nr non-restoring divider: FSM state encoding
// and the iteration-counter width helper.
package div_nr_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    // Counter only has to reach WIDTH-1 before the FSM leaves CALC.
    function automatic int cnt_w(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/div_nr_addsub.sv
// Ripple carry-chain adder/subtractor, N bits: y = a + b (sub=0) or a - b (sub=1).
module div_nr_addsub #(
    parameter int N = 17
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         sub_i,
    output logic [N-1:0] y_o
);

    logic [N-1:0] bx;
    logic [N-1:0] c;

    assign bx   = b_i ^ {N{sub_i}};
    assign c[0] = sub_i;

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign y_o[i] = a_i[i] ^ bx[i] ^ c[i];
        if (i < N - 1) begin : g_carry
            assign c[i+1] = (a_i[i] & bx[i]) | (a_i[i] & c[i]) | (bx[i] & c[i]);
        end
    end

endmodule

// File: rtl/div_nr.sv
// Iterative non-restoring divider, one quotient bit per cycle (IDLE/CALC/FIX).
// Define DIV_NR_SIGNED_EN for two's-complement operands; default is unsigned.
module div_nr
    import div_nr_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] dq_q, dq_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             dz_q, dz_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rmd_q, rmd_d;
    logic             dbz_q, dbz_d;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] dividend_mag, divisor_mag;
    logic [WIDTH:0]   as_a, as_b, as_y;
    logic             as_sub;
    logic [WIDTH-1:0] r_mag;

`ifdef DIV_NR_SIGNED_EN
    assign a_neg = dividend[WIDTH-1];
    assign b_neg = divisor[WIDTH-1];
`else
    assign a_neg = 1'b0;
    assign b_neg = 1'b0;
`endif

    // -2^(WIDTH-1) negates to itself, which is its correct unsigned magnitude.
    assign dividend_mag = a_neg ? -dividend : dividend;
    assign divisor_mag  = b_neg ? -divisor : divisor;

    // CALC: shift next dividend bit in, subtract if remainder >= 0 else add.
    // FIX: add divisor back to a negative final remainder.
    assign as_a   = (state_q == CALC) ? {rem_q[WIDTH-1:0], dq_q[WIDTH-1]} : rem_q;
    assign as_b   = {1'b0, dvs_q};
    assign as_sub = (state_q == CALC) & ~rem_q[WIDTH];

    div_nr_addsub #(.N(WIDTH + 1)) u_addsub (
        .a_i   (as_a),
        .b_i   (as_b),
        .sub_i (as_sub),
        .y_o   (as_y)
    );

    assign r_mag = rem_q[WIDTH] ? as_y[WIDTH-1:0] : rem_q[WIDTH-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dq_d    = dq_q;
        dvs_d   = dvs_q;
        dz_d    = dz_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        done_d  = 1'b0;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    dz_d    = (divisor == '0);
                    rem_d   = '0;
                    cnt_d   = '0;
                    dvs_d   = divisor_mag;
                    // A zero divisor keeps the raw dividend for the remainder output.
                    dq_d    = dz_d ? dividend : dividend_mag;
                    qneg_d  = a_neg ^ b_neg;
                    rneg_d  = a_neg;
                    state_d = dz_d ? FIX : CALC;
                end
            end
            CALC: begin
                rem_d = as_y;
                dq_d  = {dq_q[WIDTH-2:0], ~as_y[WIDTH]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (dz_q) begin
                    quo_d = '1;
                    rmd_d = dq_q;
                    dbz_d = 1'b1;
                end else begin
                    quo_d = qneg_q ? -dq_q : dq_q;
                    rmd_d = rneg_q ? -r_mag : r_mag;
                    dbz_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dq_q    <= '0;
            dvs_q   <= '0;
            dz_q    <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            done_q  <= 1'b0;
            quo_q   <= '0;
            rmd_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dq_q    <= dq_d;
            dvs_q   <= dvs_d;
            dz_q    <= dz_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            done_q  <= done_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign quotient    = quo_q;
    assign remainder   = rmd_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_nr.sv
// Bench for div_nr (WIDTH=16); build with DIV_NR_SIGNED_EN to run the signed vectors.
module tb_div_nr;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    div_nr #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // scoreboard state: packed {div_by_zero, quotient, remainder} and done edge
    logic [2*W:0] exp_q[$];
    int           exp_edge_q[$];
    int           n_vec  = 0;
    int           errors = 0;
    logic [W-1:0] hold_q  = '0;
    logic [W-1:0] hold_r  = '0;
    logic         hold_dz = 1'b0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // driver: called and returns at a negedge; start drops after acceptance
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic edz, input int lat);
        int guard = 0;
        while (busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (busy) begin
            errors++;
            $display("FAIL issue_timeout: busy still 1 after %0d cycles, expected 0", guard);
        end
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        exp_q.push_back({edz, eq, er});
        exp_edge_q.push_back(edge_cnt + lat);
        n_vec++;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // monitor: pop and compare on every done, check holding otherwise
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: done=1 at edge %0d, expected no done", edge_cnt);
                end else begin
                    logic [2*W:0] e;
                    int           ee;
                    e  = exp_q.pop_front();
                    ee = exp_edge_q.pop_front();
                    chk("quotient", quotient, e[2*W-1:W]);
                    chk("remainder", remainder, e[W-1:0]);
                    chk("div_by_zero", W'(div_by_zero), W'(e[2*W]));
                    chk("busy_in_done", W'(busy), '0);
                    chk("done_edge", W'(edge_cnt + 1), W'(ee));
                    hold_q  = e[2*W-1:W];
                    hold_r  = e[W-1:0];
                    hold_dz = e[2*W];
                end
            end else begin
                chk("hold_quotient", quotient, hold_q);
                chk("hold_remainder", remainder, hold_r);
                chk("hold_div_by_zero", W'(div_by_zero), W'(hold_dz));
            end
        end
    end

    initial begin
        int guard;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #1;
        chk("rst_busy", W'(busy), '0);
        chk("rst_done", W'(done), '0);
        chk("rst_quotient", quotient, '0);
        chk("rst_remainder", remainder, '0);
        chk("rst_div_by_zero", W'(div_by_zero), '0);
        wait_cycles(3);
        rst_n = 1'b1;

        // accepted on the first edge after reset release
        issue(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 18);

        // back-to-back on done
        issue(16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 18);
`ifdef DIV_NR_SIGNED_EN
        issue(16'h1234, 16'hFFFF, 16'hEDCC, 16'h0000, 1'b0, 18);
`else
        issue(16'h1234, 16'hFFFF, 16'h0000, 16'h1234, 1'b0, 18);
`endif

        // divide by zero then flag cleared
        issue(16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1, 2);
        issue(16'd9, 16'd3, 16'd3, 16'd0, 1'b0, 18);

        // start with new operands mid-divide is ignored
        issue(16'd1000, 16'd10, 16'd100, 16'd0, 1'b0, 18);
        wait_cycles(3);
        start    = 1'b1;
        dividend = 16'd7;
        divisor  = 16'd7;
        @(negedge clk);
        start = 1'b0;

        // reset mid-divide abandons it
        issue(16'd30000, 16'd7, 16'd4285, 16'd5, 1'b0, 18);
        wait_cycles(6);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", W'(busy), '0);
        chk("midrst_done", W'(done), '0);
        chk("midrst_quotient", quotient, '0);
        chk("midrst_remainder", remainder, '0);
        chk("midrst_div_by_zero", W'(div_by_zero), '0);
        exp_q.delete();
        exp_edge_q.delete();
        hold_q  = '0;
        hold_r  = '0;
        hold_dz = 1'b0;
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(25);
        issue(16'd30000, 16'd7, 16'd4285, 16'd5, 1'b0, 18);

        // boundaries
        issue(16'd0, 16'd5, 16'd0, 16'd0, 1'b0, 18);
        issue(16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 1'b0, 18);
        issue(16'd12345, 16'd123, 16'd100, 16'd45, 1'b0, 18);
`ifdef DIV_NR_SIGNED_EN
        issue(16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, 18);
        issue(16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 18);
        issue(16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0, 18);
        issue(16'hFFF9, 16'h0000, 16'hFFFF, 16'hFFF9, 1'b1, 2);
`else
        issue(16'd3, 16'hFFFF, 16'd0, 16'd3, 1'b0, 18);
        issue(16'h8000, 16'h0003, 16'h2AAA, 16'h0002, 1'b0, 18);
`endif

        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
        end
        wait_cycles(25);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, errors);
        $finish;
    end

endmodule
